// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver states and a parity helper.
// Used by both the receive and transmit directions.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    // Expected parity bit given the XOR-reduction of the data word.
    function automatic logic parity_bit(parity_e mode, logic dataXor);
        return (mode == PAR_ODD) ? ~dataXor : dataXor;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high serial line.
// Both stages reset to 1 so the line looks idle while in reset.
module uart_sync2 (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start bit, WIDTH data bits LSB first, optional parity, one stop bit.
// Samples mid-bit from a baud counter and flags parity and framing errors.
module uart_receiver #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int WIDTH     = 8,
    parameter int PARITY    = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             uartRx,
    output logic [WIDTH-1:0] rxData,
    output logic             rxValid,
    output logic             rxBusy,
    output logic             parityErr,
    output logic             frameErr
);

    import uart_pkg::*;

    localparam int BAUD_COUNT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_COUNT = BAUD_COUNT / 2;
    localparam int CW = $clog2(BAUD_COUNT);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_COUNT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_COUNT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(WIDTH - 1);
    localparam parity_e       PMODE     = parity_e'(PARITY);

    localparam logic [2:0] S_IDLE   = 3'(IDLE);
    localparam logic [2:0] S_START  = 3'(START);
    localparam logic [2:0] S_DATA   = 3'(DATA);
    localparam logic [2:0] S_PARITY = 3'(uart_pkg::PARITY);
    localparam logic [2:0] S_STOP   = 3'(STOP);
    localparam logic [2:0] S_BREAK  = 3'(BREAK);

    logic             rxS;
    logic             rxS_d;
    logic [1:0]       warmup;
    logic [2:0]       state;
    logic [CW-1:0]    baudCnt;
    logic [IW-1:0]    bitIdx;
    logic [WIDTH-1:0] shiftReg;
    logic             rxPar;
    logic             baudTick;
    logic             halfTick;
    logic             fallEdge;

    uart_sync2 uSync (
        .clk    (clk),
        .resetn (resetn),
        .d      (uartRx),
        .q      (rxS)
    );

    assign baudTick = (baudCnt == BAUD_LAST);
    assign halfTick = (baudCnt == HALF_LAST);
    // Ignore edges until the synchroniser holds real line data, so a line
    // that is already low when reset releases never looks like a start bit.
    assign fallEdge = (warmup == 2'd3) && rxS_d && !rxS;
    assign rxBusy   = (state != S_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxS_d     <= 1'b1;
            warmup    <= 2'd0;
            state     <= S_IDLE;
            baudCnt   <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            rxPar     <= 1'b0;
            rxData    <= '0;
            rxValid   <= 1'b0;
            parityErr <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            rxS_d   <= rxS;
            rxValid <= 1'b0;
            if (warmup != 2'd3)
                warmup <= warmup + 2'd1;
            case (state)
                S_IDLE: begin
                    baudCnt <= '0;
                    if (fallEdge)
                        state <= S_START;
                end
                S_START: begin
                    if (halfTick) begin
                        baudCnt <= '0;
                        bitIdx  <= '0;
                        state   <= rxS ? S_IDLE : S_DATA;
                    end else begin
                        baudCnt <= baudCnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baudTick) begin
                        baudCnt  <= '0;
                        shiftReg <= {rxS, shiftReg[WIDTH-1:1]};
                        if (bitIdx == BIT_LAST)
                            state <= (PMODE == PAR_NONE) ? S_STOP : S_PARITY;
                        else
                            bitIdx <= bitIdx + 1'b1;
                    end else begin
                        baudCnt <= baudCnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (baudTick) begin
                        baudCnt <= '0;
                        rxPar   <= rxS;
                        state   <= S_STOP;
                    end else begin
                        baudCnt <= baudCnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baudTick) begin
                        baudCnt   <= '0;
                        rxData    <= shiftReg;
                        parityErr <= (PMODE != PAR_NONE)
                                   && (parity_bit(PMODE, ^shiftReg) != rxPar);
                        frameErr  <= ~rxS;
                        rxValid   <= 1'b1;
                        state     <= rxS ? S_IDLE : S_BREAK;
                    end else begin
                        baudCnt <= baudCnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    baudCnt <= '0;
                    if (rxS)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed and randomized frames checked against
// a frame-level model (even parity build plus a no-parity build).
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int BAUD = 50_000_000 / 115200;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       uartRx = 1'b1;
    logic       uartRx0 = 1'b1;
    logic [7:0] rxData, rxData0;
    logic       rxValid, rxBusy, parityErr, frameErr;
    logic       rxValid0, rxBusy0, parityErr0, frameErr0;

    int nVec = 0;
    int nErr = 0;

    // Each entry: {frameErr, parityErr, data}
    logic [9:0] gotQ[$];
    logic [9:0] got0Q[$];

    uart_receiver #(.PARITY(1)) dut (
        .clk(clk), .resetn(resetn), .uartRx(uartRx),
        .rxData(rxData), .rxValid(rxValid), .rxBusy(rxBusy),
        .parityErr(parityErr), .frameErr(frameErr)
    );

    uart_receiver #(.PARITY(0)) dut0 (
        .clk(clk), .resetn(resetn), .uartRx(uartRx0),
        .rxData(rxData0), .rxValid(rxValid0), .rxBusy(rxBusy0),
        .parityErr(parityErr0), .frameErr(frameErr0)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (rxValid)
            gotQ.push_back({frameErr, parityErr, rxData});
        if (rxValid0)
            got0Q.push_back({frameErr0, parityErr0, rxData0});
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive_bit(input logic v, input bit line0);
        if (line0) uartRx0 = v;
        else uartRx = v;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stop, input bit line0);
        drive_bit(1'b0, line0);
        for (int i = 0; i < 8; i++)
            drive_bit(d[i], line0);
        if (!line0)
            drive_bit(par, line0);
        drive_bit(stop, line0);
    endtask

    // Frame-level expectation for the even-parity receiver.
    function automatic logic [9:0] model(input logic [7:0] d,
                                         input logic par, input logic stop);
        return {~stop, par != (^d), d};
    endfunction

    task automatic test_reset;
        logic [11:0] got;
        resetn = 1'b0;
        repeat (5) @(negedge clk);
        got = {rxData, rxValid, rxBusy, parityErr, frameErr};
        nVec++;
        if (got !== 12'h000) begin
            nErr++;
            $display("FAIL reset_outputs got %h want 000", got);
        end
        resetn = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_good_frame;
        logic [9:0] exp;
        gotQ.delete();
        exp = model(8'hA5, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        nVec++;
        if (gotQ.size() != 1) begin
            nErr++;
            $display("FAIL good_count got %0d want 1", gotQ.size());
        end else begin
            nVec++;
            if (gotQ[0] !== exp) begin
                nErr++;
                $display("FAIL good_frame got %h want %h", gotQ[0], exp);
            end
        end
        drive_bit(1'b1, 0);
    endtask

    task automatic test_parity_error;
        logic [9:0] exp[2];
        gotQ.delete();
        exp[0] = model(8'h01, 1'b0, 1'b1);
        exp[1] = model(8'h01, 1'b1, 1'b1);
        send_frame(8'h01, 1'b0, 1'b1, 0);
        send_frame(8'h01, 1'b1, 1'b1, 0);
        nVec++;
        if (gotQ.size() != 2) begin
            nErr++;
            $display("FAIL parity_count got %0d want 2", gotQ.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                nVec++;
                if (gotQ[i] !== exp[i]) begin
                    nErr++;
                    $display("FAIL parity_frame%0d got %h want %h",
                             i, gotQ[i], exp[i]);
                end
            end
        end
        drive_bit(1'b1, 0);
    endtask

    task automatic test_framing;
        logic [9:0] exp;
        logic [7:0] d;
        gotQ.delete();
        exp = model(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        repeat (3) drive_bit(1'b0, 0);
        nVec++;
        if (rxBusy !== 1'b1) begin
            nErr++;
            $display("FAIL break_busy got %b want 1", rxBusy);
        end
        nVec++;
        if (gotQ.size() != 1 || gotQ[0] !== exp) begin
            nErr++;
            $display("FAIL frame_err got n=%0d %h want n=1 %h",
                     gotQ.size(), (gotQ.size() > 0) ? gotQ[0] : 10'h0, exp);
        end
        gotQ.delete();
        repeat (2) drive_bit(1'b1, 0);
        nVec++;
        if (gotQ.size() != 0 || rxBusy !== 1'b0) begin
            nErr++;
            $display("FAIL break_release got n=%0d busy=%b want n=0 busy=0",
                     gotQ.size(), rxBusy);
        end
        d = 8'($urandom);
        exp = model(d, ^d, 1'b1);
        send_frame(d, ^d, 1'b1, 0);
        nVec++;
        if (gotQ.size() != 1 || gotQ[0] !== exp) begin
            nErr++;
            $display("FAIL after_break got n=%0d %h want n=1 %h",
                     gotQ.size(), (gotQ.size() > 0) ? gotQ[0] : 10'h0, exp);
        end
        drive_bit(1'b1, 0);
    endtask

    task automatic test_glitch;
        int busyCnt = 0;
        gotQ.delete();
        uartRx = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            if (i == 100) uartRx = 1'b1;
            @(negedge clk);
            if (rxBusy) busyCnt++;
        end
        nVec++;
        if (busyCnt == 0 || busyCnt >= 220) begin
            nErr++;
            $display("FAIL glitch_busy got %0d cycles want 1..219", busyCnt);
        end
        nVec++;
        if (gotQ.size() != 0 || rxBusy !== 1'b0) begin
            nErr++;
            $display("FAIL glitch_reject got n=%0d busy=%b want n=0 busy=0",
                     gotQ.size(), rxBusy);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d[3] = '{8'h00, 8'hFF, 8'h55};
        gotQ.delete();
        for (int i = 0; i < 3; i++)
            send_frame(d[i], ^d[i], 1'b1, 0);
        nVec++;
        if (gotQ.size() != 3) begin
            nErr++;
            $display("FAIL b2b_count got %0d want 3", gotQ.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                nVec++;
                if (gotQ[i] !== model(d[i], ^d[i], 1'b1)) begin
                    nErr++;
                    $display("FAIL b2b_frame%0d got %h want %h", i, gotQ[i],
                             model(d[i], ^d[i], 1'b1));
                end
            end
        end
        drive_bit(1'b1, 0);
    endtask

    task automatic test_reset_midframe;
        logic [7:0]  d = 8'h7E;
        logic [11:0] got;
        logic [9:0]  exp;
        gotQ.delete();
        drive_bit(1'b0, 0);
        for (int i = 0; i < 4; i++)
            drive_bit(d[i], 0);
        uartRx = d[4];
        repeat (200) @(negedge clk);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        got = {rxData, rxValid, rxBusy, parityErr, frameErr};
        nVec++;
        if (got !== 12'h000) begin
            nErr++;
            $display("FAIL midreset_outputs got %h want 000", got);
        end
        resetn = 1'b1;
        repeat (12) drive_bit(1'b1, 0);
        nVec++;
        if (gotQ.size() != 0 || rxBusy !== 1'b0) begin
            nErr++;
            $display("FAIL midreset_quiet got n=%0d busy=%b want n=0 busy=0",
                     gotQ.size(), rxBusy);
        end
        exp = model(8'h81, 1'b0, 1'b1);
        send_frame(8'h81, 1'b0, 1'b1, 0);
        nVec++;
        if (gotQ.size() != 1 || gotQ[0] !== exp) begin
            nErr++;
            $display("FAIL midreset_next got n=%0d %h want n=1 %h",
                     gotQ.size(), (gotQ.size() > 0) ? gotQ[0] : 10'h0, exp);
        end
        drive_bit(1'b1, 0);
    endtask

    task automatic test_random;
        logic [9:0] expQ[$];
        logic [7:0] d;
        logic       bad;
        gotQ.delete();
        for (int i = 0; i < 4; i++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(3) == 0);
            expQ.push_back(model(d, (^d) ^ bad, 1'b1));
            send_frame(d, (^d) ^ bad, 1'b1, 0);
            repeat ($urandom_range(300)) @(negedge clk);
        end
        nVec++;
        if (gotQ.size() != expQ.size()) begin
            nErr++;
            $display("FAIL rand_count got %0d want %0d",
                     gotQ.size(), expQ.size());
        end else begin
            foreach (expQ[i]) begin
                nVec++;
                if (gotQ[i] !== expQ[i]) begin
                    nErr++;
                    $display("FAIL rand_frame%0d got %h want %h",
                             i, gotQ[i], expQ[i]);
                end
            end
        end
    endtask

    task automatic test_no_parity;
        logic [7:0] d[2];
        d[0] = 8'hC3;
        d[1] = 8'($urandom);
        got0Q.delete();
        for (int i = 0; i < 2; i++)
            send_frame(d[i], 1'b0, 1'b1, 1);
        nVec++;
        if (got0Q.size() != 2) begin
            nErr++;
            $display("FAIL nopar_count got %0d want 2", got0Q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                nVec++;
                if (got0Q[i] !== {2'b00, d[i]}) begin
                    nErr++;
                    $display("FAIL nopar_frame%0d got %h want %h",
                             i, got0Q[i], {2'b00, d[i]});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_framing();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        test_no_parity();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
